// File: rtl/multicycle_control.sv
// Multicycle control unit and instruction register: sequences FETCH/DECODE/EXEC/MEM/WB
// and Moore-decodes register-file addresses and datapath controls from state and IR.
module multicycle_control (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] Instr,
    input  logic        MemReady,
    input  logic        Zero,
    output logic [4:0]  RA,
    output logic [4:0]  RB,
    output logic [4:0]  RW,
    output logic        WriteEnable,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [2:0]  State,
    output logic        Illegal
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               illegal_q, illegal_d;

    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rd_field;
    logic             unused_ok;

    assign opcode    = ir_q[31:26];
    assign rd_field  = ir_q[15:11];
    // Zero is consumed by the datapath's PCWriteCond gating; the low IR bits are immediates.
    assign unused_ok = ^{Zero, ir_q[10:0]};

    assign RA      = ir_q[25:21];
    assign RB      = ir_q[20:16];
    assign State   = state_q;
    assign Illegal = illegal_q;

    // Next-state, IR capture and sticky illegal flag
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    ir_d    = Instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_J:                                   state_d = S_FETCH;
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:      state_d = S_MEM;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (MemReady) begin
                    state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore control decode; everything is held at 0 while reset is asserted
    always_comb begin
        RW          = '0;
        WriteEnable = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (reset_n) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    if (opcode == OP_J) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'b10;
                    end
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    case (opcode)
                        OP_RTYPE: ALUOp = 2'b10;
                        OP_ADDI, OP_LW, OP_SW: ALUSrcB = 2'b10;
                        OP_BEQ: begin
                            ALUOp       = 2'b01;
                            PCWriteCond = 1'b1;
                            PCSource    = 2'b01;
                        end
                        default: ALUSrcA = 1'b0;
                    endcase
                end
                S_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = (opcode == OP_LW);
                    MemWrite = (opcode == OP_SW);
                end
                S_WB: begin
                    RW          = (opcode == OP_RTYPE) ? rd_field : RB;
                    MemtoReg    = (opcode == OP_LW);
                    WriteEnable = (RW != '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit and instruction register for the processor datapath. It sits directly upstream of the register file: it captures each fetched instruction, walks FETCH/DECODE/EXEC/MEM/WB, and drives the register-file addresses RA, RB and RW, the write strobe WriteEnable, and all datapath mux and strobe controls. Every state, stall and write decision in the datapath comes from this block.

## Interface
- No parameters. Widths are fixed by the 32-bit ISA.
- clock  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- Instr  in  32  memory read data; captured into the internal IR
- MemReady  in  1  memory handshake; the current access completes in a cycle where it is high
- Zero  in  1  ALU zero flag for BEQ
- RA, RB  out  5  register-file read addresses: IR[25:21] and IR[20:16]
- RW  out  5  register-file write address
- WriteEnable  out  1  register-file write strobe
- IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite, IorD, MemtoReg, ALUSrcA  out  1 each  datapath controls
- ALUSrcB, ALUOp, PCSource  out  2 each  datapath mux selects
- State  out  3  current state encoding, for debug
- Illegal  out  1  sticky illegal-opcode flag

## Operation
- Opcodes are IR[31:26]:
  - R-type 000000
  - ADDI 001000
  - LW 100011
  - SW 101011
  - BEQ 000100
  - J 000010
  - anything else is illegal
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Outputs are Moore-decoded from State and IR. Every control not listed for a state is 0.
- FETCH:
  - drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00
  - IRWrite and PCWrite equal MemReady
  - IR loads Instr on an edge where MemReady=1, then the block goes to DECODE; otherwise it stays in FETCH
- DECODE:
  - drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target)
  - J: PCWrite=1, PCSource=10, then FETCH
  - illegal opcode: set Illegal, then FETCH
  - all other opcodes: EXEC
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then WB
  - ADDI, LW, SW: ALUSrcA=1, ALUSrcB=10, ALUOp=00. ADDI goes to WB; LW and SW go to MEM
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then FETCH
- MEM:
  - drives IorD=1; MemRead=1 for LW, MemWrite=1 for SW
  - stays in MEM until MemReady=1, then LW goes to WB and SW goes to FETCH
  - MemRead and MemWrite are held steady for the whole wait
- WB:
  - RW = IR[15:11] for R-type, IR[20:16] for ADDI and LW
  - MemtoReg=1 for LW only
  - WriteEnable=1 unless RW==0; register 0 is never written
  - always returns to FETCH
- RA and RB are driven from IR in every state. The register file registers its read data, so BusA/BusB are valid in EXEC because DECODE presented the addresses one edge earlier.
- RW is 0 in every state except WB.
- Illegal is cleared only by reset. Fetching continues after an illegal opcode.

## Timing
- Reset (reset_n low, asynchronous): State=FETCH, IR=0, Illegal=0. Every strobe and select output is forced to 0 while reset_n is low, including MemRead and IRWrite.
- The first FETCH outputs appear in the cycle after reset_n deasserts.
- Reset asserted mid-instruction abandons it immediately: no WriteEnable, MemWrite or PCWrite is issued after the reset edge.
- Instruction cycle counts with zero wait states:
  - J: 2
  - BEQ: 3
  - R-type, ADDI, SW: 4
  - LW: 5
- Each MemReady-low cycle in FETCH or MEM adds exactly one cycle.
- MemReady is ignored in DECODE, EXEC and WB.
- A MemReady pulse arriving in the same cycle as the state entry completes the access immediately.
- The IR is stable from DECODE through WB; it changes only on the FETCH completion edge.

## Test plan
- Reset: reset_n low mid-EXEC of an R-type -> State=0, all strobes 0 immediately. Release with MemReady=1 -> IR captured at the first edge.
- R-type 0x00430820 (rs=2, rt=3, rd=1), zero-wait memory -> RA=2, RB=3 in DECODE; WB in cycle 4 with RW=1, WriteEnable=1, MemtoReg=0.
- LW 0x8C450004 with MemReady held low for 3 cycles in MEM -> MEM lasts 4 cycles with MemRead=1 and IorD=1 throughout; WB then has RW=5, MemtoReg=1; total 8 cycles.
- BEQ with Zero=1, then with Zero=0 -> PCWriteCond=1 and PCSource=01 in EXEC both times; back to FETCH after 3 cycles, WriteEnable never asserted.
- ADDI with rt=0 (0x20200007) -> reaches WB with RW=0 and WriteEnable=0.
- Opcode 111111 -> Illegal=1 after DECODE and stays 1 through a following valid J (0x08000010); J takes 2 cycles with PCSource=10.
